// File: rtl/int_controller.sv
// int_controller: user-mode trap/interrupt controller with ustatus/utvec/uepc/ucause CSRs.
// Optional build macro INT_VECTORED_EN: interrupt k redirects to utvec base + 4*(k+1).
// Without the macro, every trap redirects to the utvec base.
module int_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  irq,
  input  logic        ecall,
  input  logic        uret,
  input  logic [31:0] pc_commit,
  input  logic        stall,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        in_service,
  output logic [2:0]  pending
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned N_IRQ = 3;

  localparam logic [11:0] ADDR_USTATUS = 12'h000;
  localparam logic [11:0] ADDR_UTVEC   = 12'h005;
  localparam logic [11:0] ADDR_UEPC    = 12'h041;
  localparam logic [11:0] ADDR_UCAUSE  = 12'h042;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(8);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [N_IRQ-1:0]  r_irq_q;
  logic [N_IRQ-1:0]  r_pending;
  logic              r_uie;
  logic [XLEN-1:0]   r_utvec;
  logic [XLEN-1:0]   r_uepc;
  logic [XLEN-1:0]   r_ucause;

  logic [N_IRQ-1:0]  w_irq_rise;
  logic [N_IRQ-1:0]  w_pend_clr;
  logic [1:0]        w_irq_idx;
  logic [XLEN-1:0]   w_base;
  logic [XLEN-1:0]   w_irq_pc;
  logic              w_take_ecall;
  logic              w_take_irq;
  logic              w_take_uret;
  logic              w_redirect;
  logic [XLEN-1:0]   w_redirect_pc;
  logic              w_csr_we;
  logic [XLEN-1:0]   w_csr_wr_val;

  assign w_irq_rise  = irq & ~r_irq_q;
  assign w_base      = {r_utvec[XLEN-1:2], 2'b00};
  assign in_service  = (r_state == ST_SERVICE);
  assign pending     = r_pending;
  assign redirect    = w_redirect;
  assign redirect_pc = w_redirect_pc;

  // Lowest pending index wins (irq[0] highest priority)
  always_comb begin
    w_irq_idx = 2'd0;
    if (r_pending[0])      w_irq_idx = 2'd0;
    else if (r_pending[1]) w_irq_idx = 2'd1;
    else if (r_pending[2]) w_irq_idx = 2'd2;
  end

`ifdef INT_VECTORED_EN
  assign w_irq_pc = w_base + ((XLEN'(w_irq_idx) + XLEN'(1)) << 2);
`else
  assign w_irq_pc = w_base;
`endif

  // CSR read mux; unmapped addresses read zero
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_USTATUS: csr_rdata = {{(XLEN-1){1'b0}}, r_uie};
      ADDR_UTVEC:   csr_rdata = r_utvec;
      ADDR_UEPC:    csr_rdata = r_uepc;
      ADDR_UCAUSE:  csr_rdata = r_ucause;
      default:      csr_rdata = '0;
    endcase
  end

  // CSR write/set/clear operand applied to the current value of the addressed CSR
  always_comb begin
    w_csr_we     = (csr_op != OP_NONE);
    w_csr_wr_val = csr_rdata;
    case (csr_op)
      OP_WRITE: w_csr_wr_val = csr_wdata;
      OP_SET:   w_csr_wr_val = csr_rdata | csr_wdata;
      OP_CLEAR: w_csr_wr_val = csr_rdata & ~csr_wdata;
      default:  w_csr_wr_val = csr_rdata;
    endcase
  end

  // Trap decision, next state and zero-latency redirect; reset forces no redirect
  always_comb begin
    w_next_state  = r_state;
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    w_take_ecall  = 1'b0;
    w_take_irq    = 1'b0;
    w_take_uret   = 1'b0;
    if (rst_n && !stall) begin
      case (r_state)
        ST_IDLE: begin
          if (ecall) begin
            w_take_ecall  = 1'b1;
            w_redirect    = 1'b1;
            w_redirect_pc = w_base;
            w_next_state  = ST_SERVICE;
          end else if (r_uie && (r_pending != '0)) begin
            w_take_irq    = 1'b1;
            w_redirect    = 1'b1;
            w_redirect_pc = w_irq_pc;
            w_next_state  = ST_SERVICE;
          end else if (uret) begin
            w_redirect    = 1'b1;
            w_redirect_pc = r_uepc;
          end
        end
        ST_SERVICE: begin
          if (uret) begin
            w_take_uret   = 1'b1;
            w_redirect    = 1'b1;
            w_redirect_pc = r_uepc;
            w_next_state  = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Pending bit cleared on return from an interrupt handler
  assign w_pend_clr = (w_take_uret && r_ucause[XLEN-1]) ?
                      N_IRQ'(3'b001 << r_ucause[1:0]) : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Edge-detect history and pending latch; a new edge beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_q   <= '0;
      r_pending <= '0;
    end else begin
      r_irq_q   <= irq;
      r_pending <= (r_pending & ~w_pend_clr) | w_irq_rise;
    end
  end

  // CSR registers; trap updates override a same-cycle software write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uie    <= 1'b0;
      r_utvec  <= '0;
      r_uepc   <= '0;
      r_ucause <= '0;
    end else begin
      if (w_take_ecall || w_take_irq)                   r_uie <= 1'b0;
      else if (w_take_uret)                             r_uie <= 1'b1;
      else if (w_csr_we && (csr_addr == ADDR_USTATUS))  r_uie <= w_csr_wr_val[0];

      if (w_csr_we && (csr_addr == ADDR_UTVEC))
        r_utvec <= {w_csr_wr_val[XLEN-1:2], 2'b00};

      if (w_take_ecall)                                 r_uepc <= pc_commit + XLEN'(4);
      else if (w_take_irq)                              r_uepc <= pc_commit;
      else if (w_csr_we && (csr_addr == ADDR_UEPC))     r_uepc <= w_csr_wr_val;

      if (w_take_ecall)                                 r_ucause <= CAUSE_ECALL;
      else if (w_take_irq)                              r_ucause <= {1'b1, 29'b0, w_irq_idx};
      else if (w_csr_we && (csr_addr == ADDR_UCAUSE))   r_ucause <= w_csr_wr_val;
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller; expectations hand-computed from the requirements.
module tb_int_controller;

  logic        clk;
  logic        rst_n;
  logic [2:0]  irq;
  logic        ecall;
  logic        uret;
  logic [31:0] pc_commit;
  logic        stall;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        in_service;
  logic [2:0]  pending;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef INT_VECTORED_EN
  localparam logic [31:0] VEC0 = 32'h104;
  localparam logic [31:0] VEC1 = 32'h108;
  localparam logic [31:0] VEC2 = 32'h10C;
`else
  localparam logic [31:0] VEC0 = 32'h100;
  localparam logic [31:0] VEC1 = 32'h100;
  localparam logic [31:0] VEC2 = 32'h100;
`endif

  int_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq         (irq),
    .ecall       (ecall),
    .uret        (uret),
    .pc_commit   (pc_commit),
    .stall       (stall),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .in_service  (in_service),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    csr_addr = addr;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; ecall = 1'b0; uret = 1'b0; pc_commit = '0;
    stall = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;

    // Reset state
    #1;
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    rd(12'h005, 32'h0, "rst_utvec");
    cyc;
    rst_n = 1'b1;

    // utvec low bits read as zero
    csr_op = 2'b01; csr_addr = 12'h005; csr_wdata = 32'h103;
    cyc;
    csr_op = 2'b00;
    rd(12'h005, 32'h100, "utvec_lowbits");
    rd(12'h123, 32'h0, "unmapped_read");

    // CSRRSI ustatus 1
    csr_op = 2'b10; csr_addr = 12'h000; csr_wdata = 32'h1;
    cyc;
    csr_op = 2'b00;
    rd(12'h000, 32'h1, "ustatus_set");

    // irq[1] rises at pc 0x40
    pc_commit = 32'h40; irq = 3'b010;
    #1;
    chk("irq1_pre_redirect", 32'(redirect), 32'd0);
    chk("irq1_pre_pending", 32'(pending), 32'd0);
    cyc;
    chk("irq1_pending", 32'(pending), 32'b010);
    chk("irq1_redirect", 32'(redirect), 32'd1);
    chk("irq1_redirect_pc", redirect_pc, VEC1);
    cyc;
    chk("irq1_in_service", 32'(in_service), 32'd1);
    chk("irq1_redirect_drop", 32'(redirect), 32'd0);
    rd(12'h041, 32'h40, "irq1_uepc");
    rd(12'h042, 32'h80000001, "irq1_ucause");
    rd(12'h000, 32'h0, "irq1_uie");
    irq = 3'b000; uret = 1'b1;
    #1;
    chk("uret1_redirect", 32'(redirect), 32'd1);
    chk("uret1_pc", redirect_pc, 32'h40);
    cyc;
    uret = 1'b0;
    #1;
    chk("uret1_idle", 32'(in_service), 32'd0);
    chk("uret1_pending", 32'(pending), 32'd0);
    rd(12'h000, 32'h1, "uret1_uie");

    // irq[0] and irq[2] together
    irq = 3'b101;
    cyc;
    irq = 3'b000;
    #1;
    chk("dual_pending", 32'(pending), 32'b101);
    chk("dual_pc", redirect_pc, VEC0);
    cyc;
    rd(12'h042, 32'h80000000, "dual_cause0");
    uret = 1'b1;
    #1;
    chk("dual_uret_pc", redirect_pc, 32'h40);
    cyc;
    uret = 1'b0;
    #1;
    chk("dual_pending_after", 32'(pending), 32'b100);
    chk("dual_irq2_redirect", 32'(redirect), 32'd1);
    chk("dual_irq2_pc", redirect_pc, VEC2);
    cyc;
    rd(12'h042, 32'h80000002, "dual_cause2");
    uret = 1'b1;
    cyc;
    uret = 1'b0;
    #1;
    chk("dual_pending_clear", 32'(pending), 32'd0);

    // CSRRCI ustatus 1, then ecall with UIE=0 and pending[0]
    csr_op = 2'b11; csr_addr = 12'h000; csr_wdata = 32'h1;
    cyc;
    csr_op = 2'b00;
    rd(12'h000, 32'h0, "ustatus_clear");
    irq = 3'b001;
    cyc;
    irq = 3'b000;
    #1;
    chk("uie0_pending", 32'(pending), 32'b001);
    chk("uie0_no_redirect", 32'(redirect), 32'd0);
    pc_commit = 32'h20; ecall = 1'b1;
    #1;
    chk("ecall_redirect", 32'(redirect), 32'd1);
    chk("ecall_pc", redirect_pc, 32'h100);
    cyc;
    ecall = 1'b0;
    #1;
    chk("ecall_in_service", 32'(in_service), 32'd1);
    rd(12'h041, 32'h24, "ecall_uepc");
    rd(12'h042, 32'h8, "ecall_ucause");
    chk("ecall_pending_kept", 32'(pending), 32'b001);
    ecall = 1'b1;
    #1;
    chk("no_nest_ecall", 32'(redirect), 32'd0);
    cyc;
    ecall = 1'b0;
    #1;
    chk("no_nest_state", 32'(in_service), 32'd1);
    uret = 1'b1;
    #1;
    chk("ecall_uret_pc", redirect_pc, 32'h24);
    cyc;
    uret = 1'b0; stall = 1'b1; pc_commit = 32'h60;
    #1;
    chk("ecall_ret_pending", 32'(pending), 32'b001);
    chk("ecall_ret_idle", 32'(in_service), 32'd0);
    chk("stall_c0", 32'(redirect), 32'd0);

    // Eligible interrupt held off by stall for 3 cycles
    for (int i = 1; i < 3; i++) begin
      cyc;
      chk("stall_hold", 32'(redirect), 32'd0);
      chk("stall_state", 32'(in_service), 32'd0);
    end
    cyc;
    stall = 1'b0;
    csr_op = 2'b01; csr_addr = 12'h041; csr_wdata = 32'hDEAD0000;
    #1;
    chk("stall_release_redirect", 32'(redirect), 32'd1);
    chk("stall_release_pc", redirect_pc, VEC0);
    cyc;
    csr_op = 2'b00;
    #1;
    chk("stall_in_service", 32'(in_service), 32'd1);
    rd(12'h041, 32'h60, "trap_overrides_write");
    rd(12'h042, 32'h80000000, "stall_ucause");

    // Asynchronous reset mid-SERVICE, irq[2] held high through it
    cyc;
    irq = 3'b100; rst_n = 1'b0;
    #1;
    chk("arst_in_service", 32'(in_service), 32'd0);
    chk("arst_pending", 32'(pending), 32'd0);
    chk("arst_redirect", 32'(redirect), 32'd0);
    rd(12'h000, 32'h0, "arst_ustatus");
    rd(12'h005, 32'h0, "arst_utvec");
    rd(12'h041, 32'h0, "arst_uepc");
    rd(12'h042, 32'h0, "arst_ucause");
    cyc;
    rst_n = 1'b1;
    cyc;
    chk("held_irq_new_edge", 32'(pending), 32'b100);
    chk("held_irq_uie0", 32'(redirect), 32'd0);

    // uret in IDLE redirects to uepc without changing state
    csr_op = 2'b01; csr_addr = 12'h041; csr_wdata = 32'h80;
    cyc;
    csr_op = 2'b00; uret = 1'b1;
    #1;
    chk("idle_uret_redirect", 32'(redirect), 32'd1);
    chk("idle_uret_pc", redirect_pc, 32'h80);
    cyc;
    uret = 1'b0;
    #1;
    chk("idle_uret_state", 32'(in_service), 32'd0);
    chk("idle_uret_pulse", 32'(redirect), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
